// File: rtl/next_hop_update_if.sv
// Signal bundle for next_hop_update: control handshake, memory bus and the
// better-neighbour inputs and update results.
`timescale 1ns/1ps
interface next_hop_update_if;
    logic        en;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] besthop;
    logic [15:0] nextsinks;
    logic [15:0] bestvalue;
    logic [15:0] bestneighborID;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic [15:0] nexthop;
    logic [15:0] myqvalue;
    logic        done;

    modport master (
        input  en, start, data_in, besthop, nextsinks, bestvalue, bestneighborID,
        output address, wr_en, data_out, nexthop, myqvalue, done
    );

    modport slave (
        output en, start, data_in, besthop, nextsinks, bestvalue, bestneighborID,
        input  address, wr_en, data_out, nexthop, myqvalue, done
    );
endinterface

// File: rtl/next_hop_update.sv
// Q-routing next-hop update: reads own Q-value (and sink neighbour ID), blends
// it with the target at alpha=0.5, then writes back Q-value and next-hop ID.
`timescale 1ns/1ps
module next_hop_update (
    input  logic              clock,
    input  logic              rst,
    next_hop_update_if.master bus
);
    localparam logic [15:0] ADDR_Q    = 16'h068E;
    localparam logic [15:0] ADDR_HOP  = 16'h0690;
    localparam logic [15:0] ADDR_NBR  = 16'h0048;
    localparam logic [15:0] NONE_IDX  = 16'd65;
    localparam logic [15:0] NO_HOP    = 16'hFFFF;
    localparam logic [15:0] Q_MAX     = 16'hFFFE;
    localparam logic [15:0] HOP_BONUS = 16'h0020;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RDQ, S_RDID, S_CALC, S_WRQ, S_WRH, S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] address_reg, address_next;
    logic        wr_en_reg, wr_en_next;
    logic [15:0] data_out_reg, data_out_next;
    logic        done_reg, done_next;
    logic [15:0] nexthop_reg, nexthop_next;
    logic [15:0] myq_reg, myq_next;
    logic [15:0] qold_reg, qold_next;
    logic [15:0] target_reg, target_next;
    logic [15:0] hop_reg, hop_next;

    // 17-bit sums keep the carry, so neither the bonus nor the blend can wrap.
    logic [16:0] target_sum;
    logic [16:0] q_sum;
    logic [15:0] target_sat;
    logic [15:0] q_new;
    logic [15:0] nbr_addr;

    assign target_sum = {1'b0, bus.bestvalue} + {1'b0, HOP_BONUS};
    assign target_sat = (target_sum > {1'b0, Q_MAX}) ? Q_MAX : target_sum[15:0];
    assign q_sum      = {1'b0, qold_reg} + {1'b0, target_reg};
    assign q_new      = 16'(q_sum >> 1);
    assign nbr_addr   = ADDR_NBR + (bus.nextsinks << 1);

    always_comb begin
        state_next    = state_reg;
        address_next  = address_reg;
        wr_en_next    = wr_en_reg;
        data_out_next = data_out_reg;
        done_next     = done_reg;
        nexthop_next  = nexthop_reg;
        myq_next      = myq_reg;
        qold_next     = qold_reg;
        target_next   = target_reg;
        hop_next      = hop_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.en) begin
                    done_next   = 1'b0;
                    wr_en_next  = 1'b0;
                    qold_next   = '0;
                    target_next = '0;
                    hop_next    = '0;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.start) begin
                    address_next = ADDR_Q;
                    state_next   = S_RDQ;
                end
            end
            S_RDQ: begin
                qold_next = bus.data_in;
                myq_next  = bus.data_in;
                // A sink neighbour wins over the best neighbour.
                if (bus.nextsinks != NONE_IDX) begin
                    target_next  = '0;
                    address_next = nbr_addr;
                    state_next   = S_RDID;
                end else if (bus.besthop != NONE_IDX) begin
                    target_next = target_sat;
                    hop_next    = bus.bestneighborID;
                    state_next  = S_CALC;
                end else begin
                    hop_next      = NO_HOP;
                    address_next  = ADDR_HOP;
                    data_out_next = NO_HOP;
                    wr_en_next    = 1'b1;
                    state_next    = S_WRH;
                end
            end
            S_RDID: begin
                hop_next   = bus.data_in;
                state_next = S_CALC;
            end
            S_CALC: begin
                myq_next      = q_new;
                address_next  = ADDR_Q;
                data_out_next = q_new;
                wr_en_next    = 1'b1;
                state_next    = S_WRQ;
            end
            S_WRQ: begin
                address_next  = ADDR_HOP;
                data_out_next = hop_reg;
                wr_en_next    = 1'b1;
                state_next    = S_WRH;
            end
            S_WRH: begin
                wr_en_next   = 1'b0;
                nexthop_next = hop_reg;
                state_next   = S_DONE;
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            address_reg  <= ADDR_Q;
            wr_en_reg    <= 1'b0;
            data_out_reg <= '0;
            done_reg     <= 1'b0;
            nexthop_reg  <= NO_HOP;
            myq_reg      <= Q_MAX;
            qold_reg     <= '0;
            target_reg   <= '0;
            hop_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            address_reg  <= address_next;
            wr_en_reg    <= wr_en_next;
            data_out_reg <= data_out_next;
            done_reg     <= done_next;
            nexthop_reg  <= nexthop_next;
            myq_reg      <= myq_next;
            qold_reg     <= qold_next;
            target_reg   <= target_next;
            hop_reg      <= hop_next;
        end
    end

    assign bus.address  = address_reg;
    assign bus.wr_en    = wr_en_reg;
    assign bus.data_out = data_out_reg;
    assign bus.done     = done_reg;
    assign bus.nexthop  = nexthop_reg;
    assign bus.myqvalue = myq_reg;
endmodule

// File: tb/tb_next_hop_update.sv
// Scoreboard bench for next_hop_update: expected memory writes are queued when
// an update is launched and matched against every observed write strobe.
`timescale 1ns/1ps
module tb_next_hop_update;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] mem [0:1023];
    logic [31:0] wr_q [$];

    next_hop_update_if bus ();

    next_hop_update dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory answers the registered address combinationally, so data is
    // ready at the edge following the one that drove the address.
    assign bus.data_in = mem[bus.address[10:1]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0)
                check("wr_addr_data", {bus.address, bus.data_out}, wr_q.pop_front());
        end
    end

    function automatic void model(input logic [15:0] q, input logic [15:0] ns,
                                  input logic [15:0] bh, input logic [15:0] bv,
                                  input logic [15:0] bid, input logic [15:0] nbr,
                                  output logic [15:0] hop, output logic [15:0] qn,
                                  output int lat);
        logic [16:0] s;
        logic [15:0] t;
        t = 16'h0;
        if (ns != 16'd65) begin
            hop = nbr; lat = 6;
        end else if (bh != 16'd65) begin
            s = {1'b0, bv} + 17'h00020;
            t = (s > 17'h0FFFE) ? 16'hFFFE : s[15:0];
            hop = bid; lat = 5;
        end else begin
            hop = 16'hFFFF; lat = 3;
        end
        qn = (lat == 3) ? q : 16'(({1'b0, q} + {1'b0, t}) >> 1);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_address"},  32'(bus.address),  32'h068E);
        check({tag, "_wr_en"},    32'(bus.wr_en),    32'h0);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
        check({tag, "_done"},     32'(bus.done),     32'h0);
        check({tag, "_nexthop"},  32'(bus.nexthop),  32'hFFFF);
        check({tag, "_myq"},      32'(bus.myqvalue), 32'hFFFE);
    endtask

    task automatic run_update(input string tag, input logic [15:0] q, input logic [15:0] ns,
                              input logic [15:0] bh, input logic [15:0] bv,
                              input logic [15:0] bid, input logic [15:0] nbr,
                              input logic [15:0] exp_hop, input logic [15:0] exp_q,
                              input int exp_lat);
        int k;
        mem[16'h068E >> 1] = q;
        mem[16'h0690 >> 1] = 16'h5A5A;
        if (ns != 16'd65) mem[10'((16'h0048 + 2 * ns) >> 1)] = nbr;
        bus.nextsinks = ns; bus.besthop = bh; bus.bestvalue = bv; bus.bestneighborID = bid;
        if (exp_lat == 3) begin
            wr_q.push_back({16'h0690, 16'hFFFF});
        end else begin
            wr_q.push_back({16'h068E, exp_q});
            wr_q.push_back({16'h0690, exp_hop});
        end
        @(negedge clock); bus.en = 1'b1;
        @(negedge clock); bus.en = 1'b0;
        check({tag, "_done_cleared"}, 32'(bus.done), 32'h0);
        bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(posedge clock); k++; #1;
            // Inputs are only sampled in RDQ; scrambling them afterwards must not matter.
            if (k == 1) begin
                bus.nextsinks = 16'd65; bus.besthop = 16'd65;
                bus.bestvalue = 16'h0000; bus.bestneighborID = 16'hAAAA;
            end
        end
        check({tag, "_latency"}, 32'(k),            32'(exp_lat));
        check({tag, "_nexthop"}, 32'(bus.nexthop),  32'(exp_hop));
        check({tag, "_myq"},     32'(bus.myqvalue), 32'(exp_q));
        check({tag, "_wr_left"}, 32'(wr_q.size()),  32'd0);
        repeat (2) @(posedge clock);
        #1 check({tag, "_done_held"}, 32'(bus.done), 32'h1);
        $display("update %s: nexthop=%h myq=%h latency=%0d", tag, bus.nexthop, bus.myqvalue, k);
    endtask

    initial begin
        logic [15:0] hop, qn, q, ns, bh, bv, bid, nbr;
        int lat;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        bus.en = 1'b0; bus.start = 1'b0;
        bus.nextsinks = 16'd65; bus.besthop = 16'd65;
        bus.bestvalue = 16'h0; bus.bestneighborID = 16'h0;

        repeat (2) @(posedge clock);
        #1 check_reset_vals("reset");
        @(negedge clock) rst = 1'b0;

        // start without en must be ignored
        bus.start = 1'b1;
        repeat (3) @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        check("noen_done", 32'(bus.done), 32'h0);
        check("noen_address", 32'(bus.address), 32'h068E);
        $display("start without en: done=%b address=%h", bus.done, bus.address);

        run_update("sink",    16'h0100, 16'd3,  16'd65, 16'h0000, 16'h0000, 16'h0007, 16'h0007, 16'h0080, 6);
        run_update("best",    16'h0040, 16'd65, 16'd2,  16'h0060, 16'h0012, 16'h0000, 16'h0012, 16'h0060, 5);
        run_update("sat",     16'hFFFE, 16'd65, 16'd1,  16'hFFF0, 16'h0033, 16'h0000, 16'h0033, 16'hFFFE, 5);
        run_update("edge_fffe", 16'h0000, 16'd65, 16'd4, 16'hFFDE, 16'h0044, 16'h0000, 16'h0044, 16'h7FFF, 5);
        run_update("none",    16'h0200, 16'd65, 16'd65, 16'h1234, 16'h0055, 16'h0000, 16'hFFFF, 16'h0200, 3);
        run_update("prio",    16'h0301, 16'd0,  16'd5,  16'h0100, 16'h0099, 16'h0021, 16'h0021, 16'h0180, 6);

        for (int r = 0; r < 4; r++) begin
            q   = 16'($urandom);
            ns  = ($urandom_range(0, 2) == 0) ? 16'(($urandom_range(0, 64))) : 16'd65;
            bh  = ($urandom_range(0, 2) == 0) ? 16'd65 : 16'(($urandom_range(0, 64)));
            bv  = 16'($urandom);
            bid = 16'($urandom);
            nbr = 16'($urandom);
            model(q, ns, bh, bv, bid, nbr, hop, qn, lat);
            run_update($sformatf("rand%0d", r), q, ns, bh, bv, bid, nbr, hop, qn, lat);
        end

        // Reset while in WRQ: the Q-value write completes, the next-hop write never happens.
        mem[16'h068E >> 1] = 16'h0040;
        bus.nextsinks = 16'd65; bus.besthop = 16'd2;
        bus.bestvalue = 16'h0060; bus.bestneighborID = 16'h0012;
        wr_q.push_back({16'h068E, 16'h0060});
        @(negedge clock); bus.en = 1'b1;
        @(negedge clock); bus.en = 1'b0; bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("abort_wrq_wr_en", 32'(bus.wr_en), 32'h1);
        rst = 1'b1;
        @(posedge clock); #1 check_reset_vals("abort");
        rst = 1'b0;
        repeat (6) @(posedge clock);
        #1 check("abort_wr_left", 32'(wr_q.size()), 32'd0);
        check("abort_done", 32'(bus.done), 32'h0);
        $display("reset in WRQ: wr_en=%b done=%b nexthop=%h", bus.wr_en, bus.done, bus.nexthop);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
